routing_table_master: RTL and testbench

- Avalon-MM master that drives the 512x32 single-port on-chip routing-table memory slave (s1).
- Converts simple block commands (read or write N consecutive words from a start address) into single-word Avalon transfers.
- Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream.
- Sits between the routing-controller logic and the on-chip memory, replacing direct CPU access for bulk table load and dump.

---
 rtl/routing_table_master_pkg.sv | 15 +
 rtl/routing_table_addr_gen.sv | 30 +++
 rtl/routing_table_master.sv | 90 +++++++++
 tb/tb_routing_table_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/routing_table_master_pkg.sv
// routing_table_master_pkg: shared FSM states and routing-table memory geometry
package routing_table_master_pkg;
  localparam int RT_DEPTH  = 512;
  localparam int RT_ADDR_W = 9;
  localparam int RT_DATA_W = 32;
  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    RD_HOLD,
    DONE
  } rt_state_e;
endpackage

// File: rtl/routing_table_addr_gen.sv
// routing_table_addr_gen: word address counter and remaining-count tracker for one block command
module routing_table_addr_gen
  import routing_table_master_pkg::*;
#(
  parameter int ADDR_W = RT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W:0]   load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W:0] remaining;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end
  assign last = remaining == (ADDR_W + 1)'(1);
endmodule

// File: rtl/routing_table_master.sv
// routing_table_master: turns block read/write commands into single-word Avalon-MM transfers
module routing_table_master
  import routing_table_master_pkg::*;
#(
  parameter int ADDR_W       = RT_ADDR_W,
  parameter int DATA_W       = RT_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W:0]     cmd_len,
  output logic                cmd_done,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic [ADDR_W-1:0]   av_address,
  output logic [DATA_W/8-1:0] av_byteenable,
  output logic                av_chipselect,
  output logic                av_write,
  output logic [DATA_W-1:0]   av_writedata,
  output logic                av_clken,
  output logic                av_reset_req,
  input  logic [DATA_W-1:0]   av_readdata
);
  rt_state_e  state, next_state;
  logic [2:0] lat_cnt;
  logic       load, step, last, lat_done;
  assign load          = cmd_valid & cmd_ready;
  assign step          = state == WR_ISSUE || (state == RD_HOLD && rd_ready);
  assign lat_done      = lat_cnt == 3'd1;
  assign av_byteenable = '1;
  assign av_clken      = 1'b1;
  routing_table_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .load_addr(cmd_addr),
    .load_len (cmd_len),
    .addr     (av_address),
    .last     (last)
  );
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (load) next_state = cmd_len == '0 ? DONE : cmd_write ? WR_WAIT : RD_ISSUE;
      WR_WAIT:  if (wr_valid) next_state = WR_ISSUE;
      WR_ISSUE: next_state = last ? DONE : WR_WAIT;
      RD_ISSUE: next_state = RD_WAIT;
      RD_WAIT:  if (lat_done) next_state = RD_HOLD;
      RD_HOLD:  if (rd_ready) next_state = last ? DONE : RD_ISSUE;
      default:  next_state = IDLE;
    endcase
  end
  // Handshake/strobe outputs are registered from next_state so they line up with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      cmd_done      <= 1'b0;
      wr_ready      <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      av_chipselect <= 1'b0;
      av_write      <= 1'b0;
      av_writedata  <= '0;
      av_reset_req  <= 1'b1;
      lat_cnt       <= '0;
    end else begin
      state         <= next_state;
      cmd_ready     <= next_state == IDLE;
      cmd_done      <= next_state == DONE;
      wr_ready      <= next_state == WR_WAIT;
      rd_valid      <= next_state == RD_HOLD;
      av_chipselect <= next_state == WR_ISSUE || next_state == RD_ISSUE;
      av_write      <= next_state == WR_ISSUE;
      av_reset_req  <= 1'b0;
      if (wr_ready && wr_valid) av_writedata <= wr_data;
      if (state == RD_WAIT && lat_done) rd_data <= av_readdata;
      lat_cnt <= state == RD_ISSUE ? 3'(READ_LATENCY) : state == RD_WAIT ? lat_cnt - 3'd1 : lat_cnt;
    end
  end
endmodule

// File: tb/tb_routing_table_master.sv
// tb_routing_table_master: randomized block commands against a command-level memory model
module tb_routing_table_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_done;
  logic [8:0]  cmd_addr;
  logic [9:0]  cmd_len;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [31:0] wr_data, rd_data;
  logic [8:0]  av_address;
  logic [3:0]  av_byteenable;
  logic        av_chipselect, av_write, av_clken, av_reset_req;
  logic [31:0] av_writedata, av_readdata, rd_pipe;
  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  routing_table_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .av_address(av_address), .av_byteenable(av_byteenable),
    .av_chipselect(av_chipselect), .av_write(av_write),
    .av_writedata(av_writedata), .av_clken(av_clken),
    .av_reset_req(av_reset_req), .av_readdata(av_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
  endfunction

  // 512x32 slave with one cycle of read latency
  initial for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
  always @(posedge clk)
    if (av_chipselect) begin
      if (av_write) mem[av_address] <= av_writedata;
      else rd_pipe <= mem[av_address];
    end
  assign av_readdata = rd_pipe;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_cmd(input bit wr, input int a, input int n, input int stall, input logic [31:0] dbase);
    int acc, done_cyc, widx, ridx, held, guard, exp_done, exp_c;
    bit busy_bad, stall_bad, seq_bad, data_bad;
    logic [31:0] sv;
    logic [31:0] wd[$], ed[$], got[$], cd[$];
    int ea[$], ca[$], cc[$];
    bit cw[$];
    sv = '0; busy_bad = 0; stall_bad = 0; seq_bad = 0; data_bad = 0;
    for (int i = 0; i < n; i++) begin
      ea.push_back((a + i) % 512);
      wd.push_back(dbase != 0 ? dbase + 32'(i) : $urandom);
      ed.push_back(ref_mem[(a + i) % 512]);
    end
    if (wr) for (int i = 0; i < n; i++) ref_mem[ea[i]] = wd[i];
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready); end
    cmd_valid = 1; cmd_write = wr; cmd_addr = 9'(a); cmd_len = 10'(n); acc = cyc;
    done_cyc = -1; widx = 0; ridx = 0; held = 0; guard = 0;
    while (done_cyc < 0 && guard < 4000) begin
      tick(); guard++;
      if (cmd_done) done_cyc = cyc;
      if (cmd_ready) busy_bad = 1;
      if (av_chipselect) begin
        ca.push_back(int'(av_address)); cc.push_back(cyc); cw.push_back(av_write); cd.push_back(av_writedata);
      end
      // a competing command is held on the port while busy and must be ignored
      cmd_valid = done_cyc < 0; cmd_write = 1'($urandom); cmd_addr = 9'($urandom); cmd_len = 10'($urandom);
      wr_valid = wr && widx < n;
      wr_data  = wr_valid ? wd[widx] : $urandom;
      rd_ready = 1;
      if (rd_valid && ridx == 0 && held < stall) begin
        rd_ready = 0;
        if (held == 0) sv = rd_data;
        else if (rd_data !== sv) stall_bad = 1;
        if (av_chipselect) stall_bad = 1;
        held++;
      end
      if (wr_ready && wr_valid) widx++;
      if (rd_valid && rd_ready) begin got.push_back(rd_data); ridx++; end
    end
    cmd_valid = 0; wr_valid = 0;
    tests++;
    if (done_cyc < 0) begin fails++; $display("FAIL cmd_timeout: cmd_done not seen, required within 4000 cycles"); end
    exp_done = wr ? acc + 2 * n + 1 : acc + 3 * n + 1 + (n > 0 ? stall : 0);
    tests++;
    if (done_cyc != exp_done) begin fails++; $display("FAIL done_time: cmd_done at %0d required %0d", done_cyc - acc, exp_done - acc); end
    tick();
    tests++;
    if (cmd_done !== 1'b0 || cmd_ready !== 1'b1)
      begin fails++; $display("FAIL done_pulse: cmd_done=%b cmd_ready=%b required 0 1", cmd_done, cmd_ready); end
    tests++;
    if (busy_bad) begin fails++; $display("FAIL busy_ready: cmd_ready=1 while busy, required 0"); end
    tests++;
    if (ca.size() != n) begin fails++; $display("FAIL access_count: %0d accesses required %0d", ca.size(), n); end
    for (int i = 0; i < n && i < ca.size(); i++) begin
      exp_c = wr ? acc + 2 + 2 * i : acc + 1 + 3 * i + (i > 0 ? stall : 0);
      if (!seq_bad && (ca[i] != ea[i] || cw[i] != wr || cc[i] != exp_c || (wr && cd[i] !== wd[i]))) begin
        seq_bad = 1;
        $display("FAIL access_seq: #%0d addr=%h wr=%b t=%0d wdata=%h required addr=%h wr=%b t=%0d wdata=%h",
                 i, ca[i], cw[i], cc[i] - acc, cd[i], ea[i], wr, exp_c - acc, wd[i]);
      end
    end
    tests++;
    if (seq_bad) fails++;
    if (wr) begin
      for (int i = 0; i < n; i++)
        if (!data_bad && mem[ea[i]] !== wd[i]) begin
          data_bad = 1;
          $display("FAIL mem_contents: mem[%h]=%h required %h", ea[i], mem[ea[i]], wd[i]);
        end
    end else begin
      if (got.size() != n) begin
        data_bad = 1;
        $display("FAIL rd_count: %0d words required %0d", got.size(), n);
      end
      for (int i = 0; i < n && i < got.size(); i++)
        if (!data_bad && got[i] !== ed[i]) begin
          data_bad = 1;
          $display("FAIL rd_data: word %0d=%h required %h", i, got[i], ed[i]);
        end
    end
    tests++;
    if (data_bad) fails++;
    if (!wr && n > 0 && stall > 0) begin
      tests++;
      if (stall_bad || held != stall)
        begin fails++; $display("FAIL rd_stall: unstable=%b held=%0d required 0 %0d", stall_bad, held, stall); end
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    tests++;
    if ({cmd_ready, cmd_done, wr_ready, rd_valid, av_chipselect, av_write, av_reset_req, av_clken} !== 8'b0000_0011 ||
        rd_data !== 32'h0 || av_address !== 9'h0 || av_writedata !== 32'h0 || av_byteenable !== 4'hF) begin
      fails++;
      $display("FAIL %s: ctl=%b rd_data=%h addr=%h wdata=%h be=%h required ctl=00000011 0 0 0 f", nm,
               {cmd_ready, cmd_done, wr_ready, rd_valid, av_chipselect, av_write, av_reset_req, av_clken},
               rd_data, av_address, av_writedata, av_byteenable);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 0;
    tick();
    tests++;
    if (av_reset_req !== 1'b1 || cmd_ready !== 1'b0)
      begin fails++; $display("FAIL reset_req_hold: reset_req=%b cmd_ready=%b required 1 0", av_reset_req, cmd_ready); end
    tick();
    tests++;
    if (av_reset_req !== 1'b0 || cmd_ready !== 1'b1 || cmd_done !== 1'b0)
      begin fails++; $display("FAIL reset_req_drop: reset_req=%b cmd_ready=%b cmd_done=%b required 0 1 0", av_reset_req, cmd_ready, cmd_done); end
  endtask

  task automatic test_reset();
    tick(); tick();
    check_reset_outputs("reset_values");
    release_reset();
  endtask

  task automatic test_write_basic();
    run_cmd(1, 'h010, 4, 0, 32'hA0);
  endtask

  task automatic test_read_basic();
    run_cmd(0, 'h010, 4, 0, 0);
  endtask

  task automatic test_wrap();
    run_cmd(1, 'h1FF, 3, 0, 0);
    run_cmd(0, 'h1FF, 3, 0, 0);
  endtask

  task automatic test_rd_stall();
    run_cmd(0, 'h010, 2, 10, 0);
  endtask

  task automatic test_zero_len();
    run_cmd(1, 'h055, 0, 0, 0);
    run_cmd(0, 'h1AA, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int guard;
    bit bad;
    guard = 0; bad = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin tick(); guard++; end
    cmd_valid = 1; cmd_write = 0; cmd_addr = 9'h010; cmd_len = 10'd4;
    tick();
    cmd_valid = 0;
    tests++;
    if (av_chipselect !== 1'b1 || av_write !== 1'b0)
      begin fails++; $display("FAIL mid_issue: cs=%b wr=%b required 1 0", av_chipselect, av_write); end
    tick();
    reset = 1;
    #1 check_reset_outputs("reset_async");
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cmd_done !== 1'b0 || rd_valid !== 1'b0 || av_chipselect !== 1'b0) bad = 1;
    end
    release_reset();
    for (int i = 0; i < 4; i++) begin
      if (cmd_done !== 1'b0 || rd_valid !== 1'b0 || av_chipselect !== 1'b0) bad = 1;
      tick();
    end
    tests++;
    if (bad) begin fails++; $display("FAIL reset_abort: activity after abort, required none"); end
    run_cmd(0, 'h010, 4, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_cmd(1, 'h100, 2, 0, 0);
    run_cmd(0, 'h100, 2, 0, 0);
    run_cmd(1, 'h101, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 14; k++) begin
      bit wr;
      wr = 1'($urandom);
      run_cmd(wr, int'($urandom_range(0, 511)), int'($urandom_range(0, 12)), wr ? 0 : int'($urandom_range(0, 4)), 0);
    end
  endtask

  task automatic test_full();
    int a;
    a = int'($urandom_range(0, 511));
    run_cmd(1, a, 512, 0, 0);
    run_cmd(0, (a + 100) % 512, 512, 0, 0);
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_rd_stall();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
